// File: rtl/pixel_stream_packer_if.sv
// Pixel stream bundle: single-pixel input handshake plus packed, coordinate-tagged output beat.
// The packer takes the slave view; the pixel source / video sink take the master view.
interface pixel_stream_packer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int RBG_SIZE     = 24,
    parameter int PIX_PER_BEAT = 1
);
    logic [RBG_SIZE-1:0]              colour_i;
    logic                             in_valid;
    logic                             in_ready;
    logic                             y_down;
    logic                             frame_abort;
    logic [PIX_PER_BEAT*RBG_SIZE-1:0] colour_o;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            next_xpixel;
    logic [DATA_WIDTH-1:0]            next_ypixel;
    logic                             first;
    logic                             last_x;
    logic                             last_y;
    logic [15:0]                      frame_count;

    modport master (
        output colour_i, in_valid, y_down, frame_abort, out_ready,
        input  in_ready, colour_o, out_valid, next_xpixel, next_ypixel,
               first, last_x, last_y, frame_count
    );

    modport slave (
        input  colour_i, in_valid, y_down, frame_abort, out_ready,
        output in_ready, colour_o, out_valid, next_xpixel, next_ypixel,
               first, last_x, last_y, frame_count
    );
endinterface

// File: rtl/pixel_stream_packer.sv
// Packs PIX_PER_BEAT pixels per beat and tags each beat with raster coordinates and frame flags.
// Latency: beat valid 1 cycle after its last pixel is accepted; P=1 sustains one beat per cycle.
// Backpressure: in_ready drops only when the final gather slot is waiting on a full, stalled output register.
module pixel_stream_packer #(
    parameter int DATA_WIDTH    = 32,
    parameter int RBG_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PIX_PER_BEAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_stream_packer_if.slave  bus
);
    localparam int SLOT_W = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
    localparam int BEAT_W = PIX_PER_BEAT * RBG_SIZE;

    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(PIX_PER_BEAT - 1);
    localparam logic [SLOT_W-1:0]     SLOT_ONE  = SLOT_W'(1);
    localparam logic [DATA_WIDTH-1:0] X_LAST    = DATA_WIDTH'(SCREEN_WIDTH - PIX_PER_BEAT);
    localparam logic [DATA_WIDTH-1:0] X_STEP    = DATA_WIDTH'(PIX_PER_BEAT);
    localparam logic [DATA_WIDTH-1:0] Y_TOP     = DATA_WIDTH'(SCREEN_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] Y_ONE     = DATA_WIDTH'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic                  first;
        logic                  last_x;
        logic                  last_y;
    } meta_t;

    logic [SLOT_W-1:0]     slot_q;
    logic [BEAT_W-1:0]     gather_q;
    logic [BEAT_W-1:0]     beat_dat;
    logic [BEAT_W-1:0]     out_dat_q;
    meta_t                 beat_meta;
    meta_t                 out_meta_q;
    logic                  out_vld_q;
    logic [15:0]           frame_cnt_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [DATA_WIDTH-1:0] y_q;
    logic [DATA_WIDTH-1:0] y_eff;
    logic [DATA_WIDTH-1:0] y_start;
    logic                  dir_q;
    logic                  dir_eff;
    logic                  fresh_q;
    logic                  accept;
    logic                  beat_load;
    logic                  out_take;

    assign bus.in_ready = reset && !bus.frame_abort &&
                          ((slot_q != SLOT_LAST) || !out_vld_q || bus.out_ready);

    // Until the first edge after reset release the row counter has not yet
    // latched y_down, so the frame start is taken straight from the input.
    always_comb begin
        y_start   = bus.y_down ? Y_TOP : '0;
        dir_eff   = fresh_q ? bus.y_down : dir_q;
        y_eff     = fresh_q ? y_start : y_q;
        accept    = bus.in_valid && bus.in_ready;
        beat_load = accept && (slot_q == SLOT_LAST);
        out_take  = out_vld_q && bus.out_ready && !bus.frame_abort;

        beat_dat = gather_q;
        beat_dat[(PIX_PER_BEAT-1)*RBG_SIZE +: RBG_SIZE] = bus.colour_i;

        beat_meta.x      = x_q;
        beat_meta.y      = y_eff;
        beat_meta.last_x = (x_q == X_LAST);
        beat_meta.last_y = dir_eff ? (y_eff == '0) : (y_eff == Y_TOP);
        beat_meta.first  = (x_q == '0) && (y_eff == (dir_eff ? Y_TOP : '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q      <= '0;
            gather_q    <= '0;
            out_dat_q   <= '0;
            out_meta_q  <= '0;
            out_vld_q   <= 1'b0;
            frame_cnt_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            dir_q       <= 1'b0;
            fresh_q     <= 1'b1;
        end else begin
            fresh_q <= 1'b0;
            dir_q   <= dir_eff;
            y_q     <= y_eff;
            if (bus.frame_abort) begin
                slot_q    <= '0;
                out_vld_q <= 1'b0;
                x_q       <= '0;
                y_q       <= y_start;
                dir_q     <= bus.y_down;
            end else begin
                if (out_take) begin
                    out_vld_q <= 1'b0;
                    if (out_meta_q.last_x && out_meta_q.last_y) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                if (beat_load) begin
                    out_dat_q  <= beat_dat;
                    out_meta_q <= beat_meta;
                    out_vld_q  <= 1'b1;
                    slot_q     <= '0;
                    if (beat_meta.last_x) begin
                        x_q <= '0;
                        if (beat_meta.last_y) begin
                            y_q   <= y_start;
                            dir_q <= bus.y_down;
                        end else begin
                            y_q <= dir_eff ? (y_eff - Y_ONE) : (y_eff + Y_ONE);
                        end
                    end else begin
                        x_q <= x_q + X_STEP;
                    end
                end else if (accept) begin
                    gather_q[int'(slot_q)*RBG_SIZE +: RBG_SIZE] <= bus.colour_i;
                    slot_q <= slot_q + SLOT_ONE;
                end
            end
        end
    end

    assign bus.colour_o    = out_dat_q;
    assign bus.out_valid   = out_vld_q;
    assign bus.next_xpixel = out_meta_q.x;
    assign bus.next_ypixel = out_meta_q.y;
    assign bus.first       = out_meta_q.first;
    assign bus.last_x      = out_meta_q.last_x;
    assign bus.last_y      = out_meta_q.last_y;
    assign bus.frame_count = frame_cnt_q;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer on an 8x4 screen with P=1, P=2 and P=4 instances.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pixel_stream_packer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pixel_stream_packer_if #(.DATA_WIDTH(32), .RBG_SIZE(24), .PIX_PER_BEAT(1)) ifa ();
    pixel_stream_packer_if #(.DATA_WIDTH(32), .RBG_SIZE(24), .PIX_PER_BEAT(2)) ifb ();
    pixel_stream_packer_if #(.DATA_WIDTH(32), .RBG_SIZE(24), .PIX_PER_BEAT(4)) ifc ();

    pixel_stream_packer #(.DATA_WIDTH(32), .RBG_SIZE(24), .SCREEN_WIDTH(8),
                          .SCREEN_HEIGHT(4), .PIX_PER_BEAT(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    pixel_stream_packer #(.DATA_WIDTH(32), .RBG_SIZE(24), .SCREEN_WIDTH(8),
                          .SCREEN_HEIGHT(4), .PIX_PER_BEAT(2))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    pixel_stream_packer #(.DATA_WIDTH(32), .RBG_SIZE(24), .SCREEN_WIDTH(8),
                          .SCREEN_HEIGHT(4), .PIX_PER_BEAT(4))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    typedef struct packed {
        logic [95:0] c;
        logic [31:0] x;
        logic [31:0] y;
        logic        f;
        logic        lx;
        logic        ly;
    } beat_t;

    task automatic test_reset();
        reset = 1'b0;
        ifa.in_valid = 0; ifa.colour_i = '0; ifa.out_ready = 0; ifa.frame_abort = 0; ifa.y_down = 1;
        ifb.in_valid = 0; ifb.colour_i = '0; ifb.out_ready = 0; ifb.frame_abort = 0; ifb.y_down = 1;
        ifc.in_valid = 0; ifc.colour_i = '0; ifc.out_ready = 0; ifc.frame_abort = 0; ifc.y_down = 1;
        repeat (2) @(negedge clk);
        total++;
        if ({ifa.out_valid, ifa.in_ready, ifa.first, ifa.last_x, ifa.last_y, ifa.frame_count,
             ifa.next_xpixel, ifa.next_ypixel, ifa.colour_o} !== '0) begin
            bad++;
            $display("FAIL reset_a: v=%b rdy=%b x=%0d y=%0d fc=%0d c=%h, want all 0",
                     ifa.out_valid, ifa.in_ready, ifa.next_xpixel, ifa.next_ypixel,
                     ifa.frame_count, ifa.colour_o);
        end
        total++;
        if ({ifb.out_valid, ifb.in_ready, ifb.first, ifb.last_x, ifb.last_y, ifb.frame_count,
             ifb.next_xpixel, ifb.next_ypixel, ifb.colour_o} !== '0) begin
            bad++;
            $display("FAIL reset_b: v=%b rdy=%b x=%0d y=%0d fc=%0d c=%h, want all 0",
                     ifb.out_valid, ifb.in_ready, ifb.next_xpixel, ifb.next_ypixel,
                     ifb.frame_count, ifb.colour_o);
        end
        total++;
        if ({ifc.out_valid, ifc.in_ready, ifc.first, ifc.last_x, ifc.last_y, ifc.frame_count,
             ifc.next_xpixel, ifc.next_ypixel, ifc.colour_o} !== '0) begin
            bad++;
            $display("FAIL reset_c: v=%b rdy=%b x=%0d y=%0d fc=%0d c=%h, want all 0",
                     ifc.out_valid, ifc.in_ready, ifc.next_xpixel, ifc.next_ypixel,
                     ifc.frame_count, ifc.colour_o);
        end
        reset = 1'b1;
    endtask

    task automatic test_frame_p1();
        int ex, ey;
        logic [23:0] ec;
        ifa.out_ready = 1; ifa.y_down = 1;
        @(negedge clk);
        ifa.in_valid = 1; ifa.colour_i = 24'h0A0000;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            ex = n % 8; ey = 3 - n / 8; ec = 24'h0A0000 + 24'(n);
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.colour_o !== ec || ifa.next_xpixel !== 32'(ex) ||
                ifa.next_ypixel !== 32'(ey) || ifa.first !== (n == 0) ||
                ifa.last_x !== (ex == 7) || ifa.last_y !== (ey == 0)) begin
                bad++;
                $display("FAIL p1_beat n=%0d: v=%b c=%h x=%0d y=%0d f=%b lx=%b ly=%b, want c=%h x=%0d y=%0d f=%b lx=%b ly=%b",
                         n, ifa.out_valid, ifa.colour_o, ifa.next_xpixel, ifa.next_ypixel, ifa.first,
                         ifa.last_x, ifa.last_y, ec, ex, ey, n == 0, ex == 7, ey == 0);
            end
            total++;
            if (ifa.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL p1_in_ready n=%0d: got %b want 1", n, ifa.in_ready);
            end
            if (n < 31) ifa.colour_i = 24'h0A0000 + 24'(n + 1);
            else        ifa.in_valid = 0;
        end
        @(negedge clk);
        total++;
        if (ifa.frame_count !== 16'd1 || ifa.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL p1_frame_end: fc=%0d v=%b, want fc=1 v=0", ifa.frame_count, ifa.out_valid);
        end
    endtask

    task automatic test_pack_p2();
        int k, ex, ey;
        logic [47:0] ec;
        logic [23:0] lo, hi;
        ifb.out_ready = 1;
        @(negedge clk);
        ifb.in_valid = 1; ifb.colour_i = 24'h0B0000;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            total++;
            if (ifb.out_valid !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL p2_valid i=%0d: got %b want %b", i, ifb.out_valid, i % 2 == 1);
            end
            if (i % 2 == 1) begin
                k = i / 2; ex = (2 * k) % 8; ey = 3 - (2 * k) / 8;
                lo = 24'h0B0000 + 24'(i - 1); hi = 24'h0B0000 + 24'(i);
                ec = {hi, lo};
                total++;
                if (ifb.colour_o !== ec || ifb.next_xpixel !== 32'(ex) || ifb.next_ypixel !== 32'(ey) ||
                    ifb.first !== (k == 0) || ifb.last_x !== (ex == 6) || ifb.last_y !== (ey == 0)) begin
                    bad++;
                    $display("FAIL p2_beat k=%0d: c=%h x=%0d y=%0d f=%b lx=%b ly=%b, want c=%h x=%0d y=%0d f=%b lx=%b ly=%b",
                             k, ifb.colour_o, ifb.next_xpixel, ifb.next_ypixel, ifb.first, ifb.last_x,
                             ifb.last_y, ec, ex, ey, k == 0, ex == 6, ey == 0);
                end
            end
            if (i < 31) ifb.colour_i = 24'h0B0000 + 24'(i + 1);
            else        ifb.in_valid = 0;
        end
        @(negedge clk);
        total++;
        if (ifb.frame_count !== 16'd1) begin
            bad++;
            $display("FAIL p2_frame_count: got %0d want 1", ifb.frame_count);
        end
    endtask

    task automatic test_stall_p4();
        beat_t q[$];
        beat_t e, got;
        int slot = 0, pix = 0, beats_out = 0, beats_made = 0, b;
        logic [95:0] gat = '0;
        logic exp_ov, exp_rdy;
        for (int cyc = 0; cyc < 800 && beats_out < 16; cyc++) begin
            @(negedge clk);
            ifc.in_valid  = (pix < 64) && ($urandom_range(0, 3) != 0);
            ifc.colour_i  = 24'h0C0000 + 24'(pix);
            ifc.out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ov  = (q.size() != 0);
            exp_rdy = (slot != 3) || !exp_ov || ifc.out_ready;
            total++;
            if (ifc.in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL p4_in_ready cyc=%0d: got %b want %b (slot=%0d)", cyc, ifc.in_ready, exp_rdy, slot);
            end
            total++;
            if (ifc.out_valid !== exp_ov) begin
                bad++;
                $display("FAIL p4_out_valid cyc=%0d: got %b want %b", cyc, ifc.out_valid, exp_ov);
            end
            if (exp_ov) begin
                got.c = ifc.colour_o; got.x = ifc.next_xpixel; got.y = ifc.next_ypixel;
                got.f = ifc.first; got.lx = ifc.last_x; got.ly = ifc.last_y;
                total++;
                if (got !== q[0]) begin
                    bad++;
                    $display("FAIL p4_beat cyc=%0d: c=%h x=%0d y=%0d flags=%b%b%b, want c=%h x=%0d y=%0d flags=%b%b%b",
                             cyc, got.c, got.x, got.y, got.f, got.lx, got.ly,
                             q[0].c, q[0].x, q[0].y, q[0].f, q[0].lx, q[0].ly);
                end
                if (ifc.out_ready) begin
                    void'(q.pop_front());
                    beats_out++;
                end
            end
            if (ifc.in_valid && exp_rdy) begin
                gat[slot*24 +: 24] = ifc.colour_i;
                pix++; slot++;
                if (slot == 4) begin
                    b = beats_made % 8;
                    e.c = gat; e.x = 32'((b % 2) * 4); e.y = 32'(3 - b / 2);
                    e.f = (b == 0); e.lx = (b % 2 == 1); e.ly = (b >= 6);
                    q.push_back(e);
                    beats_made++; slot = 0;
                end
            end
        end
        total++;
        if (beats_out != 16) begin
            bad++;
            $display("FAIL p4_timeout: beats=%0d want 16", beats_out);
        end
        ifc.in_valid = 0;
        @(negedge clk);
        total++;
        if (ifc.frame_count !== 16'd2 || ifc.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL p4_frame_count: fc=%0d v=%b, want fc=2 v=0", ifc.frame_count, ifc.out_valid);
        end
    endtask

    task automatic test_y_down();
        int ex, ey, m;
        logic [23:0] ec;
        logic ely, ef;
        ifa.out_ready = 1; ifa.y_down = 1;
        @(negedge clk);
        ifa.in_valid = 1; ifa.colour_i = 24'h0D0000;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            m = n % 32; ex = n % 8;
            ey = (n < 32) ? 3 - m / 8 : m / 8;
            ely = (n < 32) ? (ey == 0) : (ey == 3);
            ef = (m == 0);
            ec = 24'h0D0000 + 24'(n);
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.colour_o !== ec || ifa.next_xpixel !== 32'(ex) ||
                ifa.next_ypixel !== 32'(ey) || ifa.first !== ef || ifa.last_x !== (ex == 7) ||
                ifa.last_y !== ely) begin
                bad++;
                $display("FAIL ydown_beat n=%0d: v=%b c=%h x=%0d y=%0d f=%b lx=%b ly=%b, want c=%h x=%0d y=%0d f=%b lx=%b ly=%b",
                         n, ifa.out_valid, ifa.colour_o, ifa.next_xpixel, ifa.next_ypixel, ifa.first,
                         ifa.last_x, ifa.last_y, ec, ex, ey, ef, ex == 7, ely);
            end
            if (n == 7) ifa.y_down = 0;
            if (n < 63) ifa.colour_i = 24'h0D0000 + 24'(n + 1);
            else        ifa.in_valid = 0;
        end
        @(negedge clk);
        total++;
        if (ifa.frame_count !== 16'd3) begin
            bad++;
            $display("FAIL ydown_frame_count: got %0d want 3", ifa.frame_count);
        end
    endtask

    task automatic test_abort();
        logic [95:0] ec;
        ifc.out_ready = 0; ifc.y_down = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifc.in_valid = 1; ifc.colour_i = 24'h0E0000 + 24'(i);
        end
        @(negedge clk);
        total++;
        if (ifc.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_pending: out_valid=%b want 1", ifc.out_valid);
        end
        ifc.frame_abort = 1; ifc.colour_i = 24'hBADBAD;
        #1;
        total++;
        if (ifc.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_ready: got %b want 0", ifc.in_ready);
        end
        @(negedge clk);
        ifc.frame_abort = 0;
        total++;
        if (ifc.out_valid !== 1'b0 || ifc.frame_count !== 16'd2) begin
            bad++;
            $display("FAIL abort_drop: v=%b fc=%0d, want v=0 fc=2", ifc.out_valid, ifc.frame_count);
        end
        ifc.out_ready = 1; ifc.colour_i = 24'h0F0000;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            ifc.colour_i = 24'h0F0000 + 24'(i);
        end
        @(negedge clk);
        ifc.in_valid = 0;
        ec = 96'h0F0003_0F0002_0F0001_0F0000;
        total++;
        if (ifc.out_valid !== 1'b1 || ifc.colour_o !== ec || ifc.next_xpixel !== 32'd0 ||
            ifc.next_ypixel !== 32'd3 || ifc.first !== 1'b1 || ifc.last_x !== 1'b0 ||
            ifc.last_y !== 1'b0 || ifc.frame_count !== 16'd2) begin
            bad++;
            $display("FAIL abort_restart: v=%b c=%h x=%0d y=%0d f=%b lx=%b ly=%b fc=%0d, want v=1 c=%h x=0 y=3 f=1 lx=0 ly=0 fc=2",
                     ifc.out_valid, ifc.colour_o, ifc.next_xpixel, ifc.next_ypixel, ifc.first,
                     ifc.last_x, ifc.last_y, ifc.frame_count, ec);
        end
    endtask

    task automatic test_reset_mid();
        ifa.y_down = 1; ifa.out_ready = 0;
        @(negedge clk);
        ifa.in_valid = 1; ifa.colour_i = 24'h111111;
        @(negedge clk);
        total++;
        if (ifa.out_valid !== 1'b1 || ifa.next_xpixel !== 32'd0 || ifa.next_ypixel !== 32'd0 ||
            ifa.first !== 1'b1 || ifa.colour_o !== 24'h111111) begin
            bad++;
            $display("FAIL mid_pending: v=%b c=%h x=%0d y=%0d f=%b, want v=1 c=111111 x=0 y=0 f=1",
                     ifa.out_valid, ifa.colour_o, ifa.next_xpixel, ifa.next_ypixel, ifa.first);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ifa.out_valid, ifa.in_ready, ifa.first, ifa.last_x, ifa.last_y, ifa.frame_count,
             ifa.next_xpixel, ifa.next_ypixel, ifa.colour_o} !== '0) begin
            bad++;
            $display("FAIL mid_reset: v=%b rdy=%b x=%0d y=%0d fc=%0d c=%h, want all 0",
                     ifa.out_valid, ifa.in_ready, ifa.next_xpixel, ifa.next_ypixel,
                     ifa.frame_count, ifa.colour_o);
        end
        ifa.in_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        ifa.in_valid = 1; ifa.colour_i = 24'h222222; ifa.out_ready = 1;
        @(negedge clk);
        ifa.in_valid = 0;
        total++;
        if (ifa.out_valid !== 1'b1 || ifa.colour_o !== 24'h222222 || ifa.next_xpixel !== 32'd0 ||
            ifa.next_ypixel !== 32'd3 || ifa.first !== 1'b1 || ifa.frame_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_restart: v=%b c=%h x=%0d y=%0d f=%b fc=%0d, want v=1 c=222222 x=0 y=3 f=1 fc=0",
                     ifa.out_valid, ifa.colour_o, ifa.next_xpixel, ifa.next_ypixel, ifa.first, ifa.frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_frame_p1();
        test_pack_p2();
        test_stall_p4();
        test_y_down();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
